// File: rtl/instruction_decode_pipe_if.sv
// Decode-stage bus: fetch payload, write-back port,
// EX hazard inputs and the registered ID/EX bundle.
interface instruction_decode_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]     programCounterIn;
  logic [31:0]               instruction;
  logic                      inValid;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0]     writeData;
  logic                      regWrite;
  logic                      exMemRead;
  logic [REG_ADDR_WIDTH-1:0] exWriteRegister;
  logic                      stall;
  logic                      outValid;
  logic [1:0]                writeBackControl;
  logic [2:0]                memAccessControl;
  logic [3:0]                calculationControl;
  logic [DATA_WIDTH-1:0]     programCounterOut;
  logic [DATA_WIDTH-1:0]     readData1;
  logic [DATA_WIDTH-1:0]     readData2;
  logic [DATA_WIDTH-1:0]     immediateOperand;
  logic [REG_ADDR_WIDTH-1:0] writeRegister0;
  logic [REG_ADDR_WIDTH-1:0] writeRegister1;

  modport master (
    output programCounterIn, instruction, inValid,
    output flush, writeRegister, writeData, regWrite,
    output exMemRead, exWriteRegister,
    input  stall, outValid, writeBackControl,
    input  memAccessControl, calculationControl,
    input  programCounterOut, readData1, readData2,
    input  immediateOperand, writeRegister0,
    input  writeRegister1
  );

  modport slave (
    input  programCounterIn, instruction, inValid,
    input  flush, writeRegister, writeData, regWrite,
    input  exMemRead, exWriteRegister,
    output stall, outValid, writeBackControl,
    output memAccessControl, calculationControl,
    output programCounterOut, readData1, readData2,
    output immediateOperand, writeRegister0,
    output writeRegister1
  );
endinterface

// File: rtl/instruction_decode_pipe.sv
// Instruction decode stage: register file, control
// decode, load-use hazard detection and ID/EX register.
module instruction_decode_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      resetN,
  instruction_decode_pipe_if.slave  bus
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam int AW   = REG_ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;

  logic [DW-1:0] r_regs [NREG];

  logic [5:0]    w_opcode;
  logic [AW-1:0] w_rs;
  logic [AW-1:0] w_rt;
  logic [AW-1:0] w_rd;
  logic [15:0]   w_imm;
  logic [DW-1:0] w_ext;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd2;
  logic          w_opR;
  logic          w_opLw;
  logic          w_opSw;
  logic          w_opBeq;
  logic          w_opAddi;
  logic          w_legal;
  logic [1:0]    w_wb;
  logic [2:0]    w_mem;
  logic [3:0]    w_calc;
  logic          w_match;
  logic          w_stall;
  logic          w_take;

  logic          r_valid;
  logic [1:0]    r_wb;
  logic [2:0]    r_mem;
  logic [3:0]    r_calc;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_wr0;
  logic [AW-1:0] r_wr1;

  assign w_opcode = bus.instruction[31:26];
  assign w_rs     = bus.instruction[21 +: AW];
  assign w_rt     = bus.instruction[16 +: AW];
  assign w_rd     = bus.instruction[11 +: AW];
  assign w_imm    = bus.instruction[15:0];
  assign w_ext    = {{(DW-16){w_imm[15]}}, w_imm};

  assign w_opR    = (w_opcode == 6'h00);
  assign w_opLw   = (w_opcode == 6'h23);
  assign w_opSw   = (w_opcode == 6'h2B);
  assign w_opBeq  = (w_opcode == 6'h04);
  assign w_opAddi = (w_opcode == 6'h08);

  // Register 0 is hardwired; a same-cycle write wins over the array.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs != '0) begin
      if (bus.regWrite && bus.writeRegister == w_rs)
        w_rd1 = bus.writeData;
      else
        w_rd1 = r_regs[w_rs];
    end
    if (w_rt != '0) begin
      if (bus.regWrite && bus.writeRegister == w_rt)
        w_rd2 = bus.writeData;
      else
        w_rd2 = r_regs[w_rt];
    end
  end

  // Opcode to {regWrite,memToReg}, {branch,memRead,memWrite},
  // {regDst,aluOp,aluSrc}; unknown opcodes decode to a bubble.
  always_comb begin
    w_wb    = 2'b00;
    w_mem   = 3'b000;
    w_calc  = 4'b0000;
    w_legal = 1'b0;
    unique case (1'b1)
      w_opR: begin
        w_wb    = 2'b10;
        w_calc  = 4'b1100;
        w_legal = 1'b1;
      end
      w_opLw: begin
        w_wb    = 2'b11;
        w_mem   = 3'b010;
        w_calc  = 4'b0001;
        w_legal = 1'b1;
      end
      w_opSw: begin
        w_mem   = 3'b001;
        w_calc  = 4'b0001;
        w_legal = 1'b1;
      end
      w_opBeq: begin
        w_mem   = 3'b100;
        w_calc  = 4'b0010;
        w_legal = 1'b1;
      end
      w_opAddi: begin
        w_wb    = 2'b10;
        w_calc  = 4'b0001;
        w_legal = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_match = (bus.exWriteRegister == w_rs) ||
                   (bus.exWriteRegister == w_rt);
  // Flush already kills the decode slot, so it masks the stall.
  assign w_stall = bus.inValid && bus.exMemRead &&
                   (bus.exWriteRegister != '0) &&
                   w_match && !bus.flush;
  assign w_take  = bus.inValid && !w_stall && !bus.flush;

  // Write-back port; independent of stall and flush.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (bus.regWrite && bus.writeRegister != '0) begin
      r_regs[bus.writeRegister] <= bus.writeData;
    end
  end

  // ID/EX register; bubbles clear controls and hold data fields.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_mem   <= '0;
      r_calc  <= '0;
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_wr0   <= '0;
      r_wr1   <= '0;
    end else begin
      r_valid <= w_take && w_legal;
      r_wb    <= w_take ? w_wb   : 2'b00;
      r_mem   <= w_take ? w_mem  : 3'b000;
      r_calc  <= w_take ? w_calc : 4'b0000;
      if (w_take) begin
        r_pc  <= bus.programCounterIn;
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
        r_imm <= w_ext;
        r_wr0 <= w_rt;
        r_wr1 <= w_rd;
      end
    end
  end

  assign bus.stall              = w_stall;
  assign bus.outValid           = r_valid;
  assign bus.writeBackControl   = r_wb;
  assign bus.memAccessControl   = r_mem;
  assign bus.calculationControl = r_calc;
  assign bus.programCounterOut  = r_pc;
  assign bus.readData1          = r_rd1;
  assign bus.readData2          = r_rd2;
  assign bus.immediateOperand   = r_imm;
  assign bus.writeRegister0     = r_wr0;
  assign bus.writeRegister1     = r_wr1;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Directed bench for instruction_decode_pipe with
// hand-computed expectations per scenario.
module tb_instruction_decode_pipe;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;

  instruction_decode_pipe_if #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)
  ) bus ();

  instruction_decode_pipe #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc,
                       input logic [31:0] ins,
                       input logic v);
    bus.programCounterIn = pc;
    bus.instruction      = ins;
    bus.inValid          = v;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    bus.flush = 0; bus.regWrite = 0;
    bus.writeRegister = 0; bus.writeData = 0;
    bus.exMemRead = 0; bus.exWriteRegister = 0;
    tick(); tick();
    checks++;
    if (bus.outValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%0h exp=0", bus.outValid);
    end
    checks++;
    if ({bus.writeBackControl, bus.memAccessControl,
         bus.calculationControl} !== 9'h0) begin
      errors++;
      $display("FAIL rst_ctrl got=%0h exp=0",
        {bus.writeBackControl, bus.memAccessControl,
         bus.calculationControl});
    end
    checks++;
    if ({bus.readData1, bus.readData2, bus.immediateOperand,
         bus.programCounterOut} !== 128'h0) begin
      errors++;
      $display("FAIL rst_data got=%0h exp=0",
        {bus.readData1, bus.readData2,
         bus.immediateOperand, bus.programCounterOut});
    end
    resetN = 1'b1;
  endtask

  task automatic test_bypass();
    bus.regWrite = 1; bus.writeRegister = 1;
    bus.writeData = 32'hFFFF_FFFF;
    drive(32'h40, 32'h0001_1000, 1'b1);
    tick();
    checks++;
    if (bus.readData2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL byp_rd2 got=%0h exp=ffffffff", bus.readData2);
    end
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL byp_rd1 got=%0h exp=0", bus.readData1);
    end
    checks++;
    if (bus.outValid !== 1'b1 || bus.writeBackControl !== 2'b10 ||
        bus.memAccessControl !== 3'b000 ||
        bus.calculationControl !== 4'b1100) begin
      errors++;
      $display("FAIL rtype_ctrl got=%0h_%0h_%0h_%0h exp=1_2_0_c",
        bus.outValid, bus.writeBackControl,
        bus.memAccessControl, bus.calculationControl);
    end
    checks++;
    if (bus.writeRegister0 !== 5'd1 || bus.writeRegister1 !== 5'd2 ||
        bus.programCounterOut !== 32'h40) begin
      errors++;
      $display("FAIL rtype_fields got=%0h_%0h_%0h exp=1_2_40",
        bus.writeRegister0, bus.writeRegister1,
        bus.programCounterOut);
    end
    bus.regWrite = 0;
    tick();
    checks++;
    if (bus.readData2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rf_rd2 got=%0h exp=ffffffff", bus.readData2);
    end
  endtask

  task automatic test_reg0();
    bus.regWrite = 1; bus.writeRegister = 0;
    bus.writeData = 32'h1234;
    drive(32'h44, 32'h0000_0000, 1'b1);
    tick();
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_byp got=%0h exp=0", bus.readData1);
    end
    bus.regWrite = 0;
    tick();
    checks++;
    if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
      errors++;
      $display("FAIL r0_read got=%0h_%0h exp=0_0",
        bus.readData1, bus.readData2);
    end
  endtask

  task automatic test_lw();
    drive(32'h100, 32'h8C22_FFFC, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.writeBackControl !== 2'b11 ||
        bus.memAccessControl !== 3'b010 ||
        bus.calculationControl !== 4'b0001) begin
      errors++;
      $display("FAIL lw_ctrl got=%0h_%0h_%0h_%0h exp=1_3_2_1",
        bus.outValid, bus.writeBackControl,
        bus.memAccessControl, bus.calculationControl);
    end
    checks++;
    if (bus.immediateOperand !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL lw_imm got=%0h exp=fffffffc",
        bus.immediateOperand);
    end
    checks++;
    if (bus.writeRegister0 !== 5'd2 ||
        bus.readData1 !== 32'hFFFF_FFFF ||
        bus.programCounterOut !== 32'h100) begin
      errors++;
      $display("FAIL lw_fields got=%0h_%0h_%0h exp=2_ffffffff_100",
        bus.writeRegister0, bus.readData1,
        bus.programCounterOut);
    end
  endtask

  task automatic test_decode_types();
    logic [31:0] ins [4];
    logic [8:0]  ctl [4];
    logic        vld [4];
    logic [31:0] imm [4];
    ins = '{32'hAC00_0004, 32'h1000_FFFE,
            32'h2001_0005, 32'hFC00_0000};
    ctl = '{9'b00_001_0001, 9'b00_100_0010,
            9'b10_000_0001, 9'b00_000_0000};
    vld = '{1'b1, 1'b1, 1'b1, 1'b0};
    imm = '{32'h4, 32'hFFFF_FFFE, 32'h5, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(32'h200, ins[i], 1'b1);
      tick();
      checks++;
      if (bus.outValid !== vld[i] ||
          {bus.writeBackControl, bus.memAccessControl,
           bus.calculationControl} !== ctl[i]) begin
        errors++;
        $display("FAIL dec%0d got=%0h_%0h exp=%0h_%0h", i,
          bus.outValid, {bus.writeBackControl,
          bus.memAccessControl, bus.calculationControl},
          vld[i], ctl[i]);
      end
      if (vld[i]) begin
        checks++;
        if (bus.immediateOperand !== imm[i]) begin
          errors++;
          $display("FAIL dec%0d_imm got=%0h exp=%0h", i,
            bus.immediateOperand, imm[i]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    drive(32'h300, 32'h2001_0005, 1'b0);
    tick();
    checks++;
    if (bus.outValid !== 1'b0 || bus.writeBackControl !== 2'b00 ||
        bus.calculationControl !== 4'b0000) begin
      errors++;
      $display("FAIL inv_bubble got=%0h_%0h_%0h exp=0_0_0",
        bus.outValid, bus.writeBackControl,
        bus.calculationControl);
    end
  endtask

  task automatic test_load_use();
    bus.regWrite = 1; bus.writeRegister = 3;
    bus.writeData = 32'hA5A5;
    bus.exMemRead = 1; bus.exWriteRegister = 2;
    drive(32'h400, 32'h0040_0000, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_rs_stall got=%0h exp=1", bus.stall);
    end
    tick();
    checks++;
    if (bus.outValid !== 1'b0 ||
        {bus.writeBackControl, bus.memAccessControl,
         bus.calculationControl} !== 9'h0) begin
      errors++;
      $display("FAIL lu_bubble got=%0h_%0h exp=0_0",
        bus.outValid, {bus.writeBackControl,
        bus.memAccessControl, bus.calculationControl});
    end
    drive(32'h400, 32'h0002_0000, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_stall got=%0h exp=1", bus.stall);
    end
    bus.exWriteRegister = 0;
    drive(32'h400, 32'h0000_0000, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_r0_stall got=%0h exp=0", bus.stall);
    end
    bus.exMemRead = 0; bus.exWriteRegister = 2;
    drive(32'h404, 32'h0040_0000, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_nomem_stall got=%0h exp=0", bus.stall);
    end
    tick();
    bus.regWrite = 0;
    drive(32'h408, 32'h0060_0000, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.readData1 !== 32'hA5A5) begin
      errors++;
      $display("FAIL lu_wr_in_stall got=%0h_%0h exp=1_a5a5",
        bus.outValid, bus.readData1);
    end
  endtask

  task automatic test_flush();
    bus.exMemRead = 1; bus.exWriteRegister = 2;
    bus.flush = 1;
    drive(32'h500, 32'h0040_0000, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL fl_stall got=%0h exp=0", bus.stall);
    end
    tick();
    checks++;
    if (bus.outValid !== 1'b0 || bus.writeBackControl !== 2'b00) begin
      errors++;
      $display("FAIL fl_hz_bubble got=%0h_%0h exp=0_0",
        bus.outValid, bus.writeBackControl);
    end
    bus.exMemRead = 0;
    drive(32'h504, 32'h2001_0005, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b0 || bus.calculationControl !== 4'b0) begin
      errors++;
      $display("FAIL fl_bubble got=%0h_%0h exp=0_0",
        bus.outValid, bus.calculationControl);
    end
    bus.flush = 0;
  endtask

  task automatic test_back_to_back();
    drive(32'h600, 32'h2004_0007, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.writeBackControl !== 2'b10 ||
        bus.immediateOperand !== 32'h7 ||
        bus.writeRegister0 !== 5'd4 ||
        bus.programCounterOut !== 32'h600) begin
      errors++;
      $display("FAIL b2b_0 got=%0h_%0h_%0h_%0h_%0h exp=1_2_7_4_600",
        bus.outValid, bus.writeBackControl, bus.immediateOperand,
        bus.writeRegister0, bus.programCounterOut);
    end
    drive(32'h604, 32'h8C25_FFF0, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.writeBackControl !== 2'b11 ||
        bus.immediateOperand !== 32'hFFFF_FFF0 ||
        bus.writeRegister0 !== 5'd5 ||
        bus.programCounterOut !== 32'h604) begin
      errors++;
      $display("FAIL b2b_1 got=%0h_%0h_%0h_%0h_%0h exp=1_3_fffffff0_5_604",
        bus.outValid, bus.writeBackControl, bus.immediateOperand,
        bus.writeRegister0, bus.programCounterOut);
    end
  endtask

  task automatic test_async_reset();
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.outValid !== 1'b0 ||
        {bus.writeBackControl, bus.memAccessControl,
         bus.calculationControl} !== 9'h0 ||
        bus.immediateOperand !== 32'h0 ||
        bus.programCounterOut !== 32'h0) begin
      errors++;
      $display("FAIL arst_out got=%0h_%0h_%0h_%0h exp=0_0_0_0",
        bus.outValid, {bus.writeBackControl,
        bus.memAccessControl, bus.calculationControl},
        bus.immediateOperand, bus.programCounterOut);
    end
    #2;
    resetN = 1'b1;
    drive(32'h700, 32'h0023_0000, 1'b1);
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.readData1 !== 32'h0 ||
        bus.readData2 !== 32'h0) begin
      errors++;
      $display("FAIL arst_after got=%0h_%0h_%0h exp=1_0_0",
        bus.outValid, bus.readData1, bus.readData2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_bypass();
    test_reg0();
    test_lw();
    test_decode_types();
    test_invalid();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_decode_pipe.md
INSTRUCTION_DECODE_PIPE -- requirements
Module: instruction_decode_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register and data path width (at least 16).
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5, giving 2^REG_ADDR_WIDTH registers, with register addresses taken from the low bits of the instruction rs, rt and rd fields.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports programCounterIn (input, DATA_WIDTH bits) and instruction (input, 32 bits): fetch-stage payload.
REQ-006 The block SHALL have port inValid, input, 1 bit: the fetch payload is valid this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: discard the instruction in decode and the ID/EX register contents.
REQ-008 The block SHALL have ports writeRegister (input, REG_ADDR_WIDTH bits), writeData (input, DATA_WIDTH bits) and regWrite (input, 1 bit): the write-back port.
REQ-009 The block SHALL have ports exMemRead (input, 1 bit) and exWriteRegister (input, REG_ADDR_WIDTH bits): the instruction currently in EX, used for hazard detection.
REQ-010 The block SHALL have port stall, output, 1 bit, combinational: fetch SHALL hold PC and instruction.
REQ-011 The block SHALL have registered outputs outValid (1 bit), writeBackControl (2 bits), memAccessControl (3 bits), calculationControl (4 bits), programCounterOut, readData1, readData2 and immediateOperand (DATA_WIDTH bits each), and writeRegister0 and writeRegister1 (REG_ADDR_WIDTH bits each).

Function
REQ-012 Instruction fields SHALL be: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
REQ-013 Decode SHALL be by opcode, with control words writeBackControl = {regWrite, memToReg}, memAccessControl = {branch, memRead, memWrite} and calculationControl = {regDst, aluOp[1:0], aluSrc}, as follows:
- 0x00 (R-type): WB=10, MEM=000, CALC=1_10_0.
- 0x23 (lw): WB=11, MEM=010, CALC=0_00_1.
- 0x2B (sw): WB=00, MEM=001, CALC=0_00_1.
- 0x04 (beq): WB=00, MEM=100, CALC=0_01_0.
- 0x08 (addi): WB=10, MEM=000, CALC=0_00_1.
- Any other opcode: all control bits zero and outValid=0 (bubble).
REQ-014 The register file SHALL have 2 combinational read ports (rs, rt) and 1 write port written on the clock edge when regWrite=1.
REQ-015 Register 0 SHALL always read as zero, and writes to it SHALL be ignored.
REQ-016 The register file SHALL bypass same-cycle writes: if regWrite=1 and writeRegister equals a nonzero source address, that read port SHALL return writeData in the same cycle.
REQ-017 immediateOperand SHALL be imm sign-extended to DATA_WIDTH.
REQ-018 writeRegister0 SHALL capture rt and writeRegister1 SHALL capture rd.
REQ-019 A load-use hazard SHALL be detected as: stall = inValid and exMemRead and exWriteRegister≠0 and (exWriteRegister==rs or exWriteRegister==rt).
REQ-020 When stall=1, the ID/EX register SHALL load a bubble: outValid=0 and all control bits 0, with data fields don't-care but deterministic (held).
REQ-021 When inValid=0, the ID/EX register SHALL load a bubble.
REQ-022 flush=1 SHALL force a bubble on the next edge and SHALL override stall, so stall output is 0 while flush=1.
REQ-023 Latency SHALL be one cycle, from a valid, unstalled instruction at the input to registered outputs.
REQ-024 Register file writes SHALL proceed regardless of stall or flush.

Reset
REQ-025 While resetN=0, all outputs SHALL be 0, outValid SHALL be 0, and all registers SHALL be cleared to 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight instruction.
REQ-027 The first edge after deassertion SHALL decode normally.

Verification
REQ-028 Scenario, write bypass: regWrite=1, writeRegister=1, writeData=0xFFFF_FFFF, instruction 0x00011000 (rs=0, rt=1) -> same cycle readData2 path = 0xFFFFFFFF; next edge readData2 = 0xFFFFFFFF, readData1 = 0.
REQ-029 Scenario, register 0: write 0x1234 to register 0, then read rs=0 -> readData1 = 0.
REQ-030 Scenario, lw decode: instruction 0x8C22FFFC -> writeBackControl=11, memAccessControl=010, calculationControl=0001, immediateOperand=0xFFFFFFFC, writeRegister0=2, outValid=1 after one edge.
REQ-031 Scenario, load-use: exMemRead=1, exWriteRegister=2, instruction with rs=2 -> stall=1 the same cycle; next edge outValid=0 and controls 0.
REQ-032 Scenario, flush versus stall: assert flush and the hazard together -> stall=0 and a bubble on the next edge.
REQ-033 Scenario, reset: assert resetN=0 between edges with outValid=1 -> outputs 0 immediately; a prior-written register reads 0 after release.
